// File: rtl/mul_sub_pipe.sv
// Two-stage pipelined XOUT = A -/+ COEF*B with valid/ready handshake on both sides.
// Define MUL_SUB_SAT_EN to clamp XOUT to [0, 2**WIDTH-1] instead of wrapping.
`timescale 1ns/1ps
module mul_sub_pipe #(
   parameter int WIDTH  = 8,
   parameter int COEF   = 7,
   parameter int CWIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             MODE,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] XOUT,
   output logic             OVF
);

   localparam int PW = WIDTH + CWIDTH;
   localparam int RW = PW + 2;
   localparam logic [CWIDTH-1:0] COEF_C = CWIDTH'(COEF);

   logic             v1_q;
   logic             v2_q;
   logic [WIDTH-1:0] a_q;
   logic             mode_q;
   logic [PW-1:0]    p_q;
   logic [WIDTH-1:0] xout_q;
   logic             ovf_q;

   logic             s1_en_s;
   logic             s2_en_s;
   logic             in_xfer_s;
   logic [PW-1:0]    p_d;
   logic [RW-1:0]    r_s;
   logic             neg_s;
   logic             hi_s;
   logic [WIDTH-1:0] xout_d;
   logic             ovf_d;

   // Ready chain: a stage may load when it is empty or the stage after it is moving.
   assign s2_en_s   = !v2_q || OUT_READY;
   assign s1_en_s   = !v1_q || s2_en_s;
   assign in_xfer_s = IN_VALID && s1_en_s;
   assign IN_READY  = s1_en_s;
   assign OUT_VALID = v2_q;
   assign XOUT      = xout_q;
   assign OVF       = ovf_q;

   // Full-width product so no bits of COEF*B are lost before the sum/difference.
   assign p_d = PW'(B) * PW'(COEF_C);

   // Two guard bits above the product width keep the signed result exact.
   always_comb begin
      r_s = {RW{1'b0}};
      if (mode_q) begin
         r_s = RW'(a_q) + RW'(p_q);
      end else begin
         r_s = RW'(a_q) - RW'(p_q);
      end
   end

   assign neg_s = r_s[RW-1];
   assign hi_s  = |r_s[RW-2:WIDTH];
   assign ovf_d = neg_s || hi_s;

   // Result selection: clamp in the saturating build, plain truncation otherwise.
   always_comb begin
      xout_d = r_s[WIDTH-1:0];
`ifdef MUL_SUB_SAT_EN
      if (neg_s) begin
         xout_d = {WIDTH{1'b0}};
      end else if (hi_s) begin
         xout_d = {WIDTH{1'b1}};
      end else begin
         xout_d = r_s[WIDTH-1:0];
      end
`else
      xout_d = r_s[WIDTH-1:0];
`endif
   end

   // Stage 1: capture operands and product on an input transfer.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         v1_q   <= 1'b0;
         a_q    <= {WIDTH{1'b0}};
         mode_q <= 1'b0;
         p_q    <= {PW{1'b0}};
      end else if (in_xfer_s) begin
         v1_q   <= 1'b1;
         a_q    <= A;
         mode_q <= MODE;
         p_q    <= p_d;
      end else if (s1_en_s) begin
         v1_q   <= 1'b0;
      end
   end

   // Stage 2: result registers only change when real data arrives, so an idle
   // pipeline keeps the last result visible.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         v2_q   <= 1'b0;
         xout_q <= {WIDTH{1'b0}};
         ovf_q  <= 1'b0;
      end else if (s2_en_s) begin
         v2_q <= v1_q;
         if (v1_q) begin
            xout_q <= xout_d;
            ovf_q  <= ovf_d;
         end
      end
   end

endmodule

// File: tb/tb_mul_sub_pipe.sv
// Directed self-checking bench for mul_sub_pipe (COEF=7, WIDTH=8); expected
// values follow MUL_SUB_SAT_EN when it is defined.
`timescale 1ns/1ps
module tb_mul_sub_pipe;

   logic       CLK;
   logic       RST_N;
   logic       IN_VALID;
   logic       IN_READY;
   logic [7:0] A;
   logic [7:0] B;
   logic       MODE;
   logic       OUT_VALID;
   logic       OUT_READY;
   logic [7:0] XOUT;
   logic       OVF;

   int n_checks = 0;
   int n_pass   = 0;

   mul_sub_pipe #(.WIDTH(8), .COEF(7), .CWIDTH(8)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .A         (A),
      .B         (B),
      .MODE      (MODE),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .XOUT      (XOUT),
      .OVF       (OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input int observed, input int expected);
      n_checks++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
   endtask

   // Reference: exact integer arithmetic, then wrap or clamp.
   function automatic int model_x(input int a, input int b, input int mode);
      int r;
      r = (mode != 0) ? a + 7 * b : a - 7 * b;
`ifdef MUL_SUB_SAT_EN
      if (r < 0) return 0;
      if (r > 255) return 255;
      return r;
`else
      return r & 255;
`endif
   endfunction

   function automatic int model_ovf(input int a, input int b, input int mode);
      int r;
      r = (mode != 0) ? a + 7 * b : a - 7 * b;
      return ((r < 0) || (r > 255)) ? 1 : 0;
   endfunction

   task automatic send_one(input string tag, input int a, input int b, input int mode,
                           input int exp_x, input int exp_ovf);
      IN_VALID = 1'b1;
      A = 8'(a);
      B = 8'(b);
      MODE = mode[0];
      check({tag, "_in_ready"}, int'(IN_READY), 1);
      step();
      IN_VALID = 1'b0;
      check({tag, "_lat1"}, int'(OUT_VALID), 0);
      step();
      check({tag, "_valid"}, int'(OUT_VALID), 1);
      check({tag, "_xout"}, int'(XOUT), exp_x);
      check({tag, "_ovf"}, int'(OVF), exp_ovf);
      step();
   endtask

   int ra [16];
   int rb [16];
   int rm [16];

   initial begin
      RST_N = 1'b0;
      IN_VALID = 1'b0;
      A = 8'd0;
      B = 8'd0;
      MODE = 1'b0;
      OUT_READY = 1'b1;
      #12;
      check("rst_out_valid", int'(OUT_VALID), 0);
      check("rst_xout", int'(XOUT), 0);
      check("rst_ovf", int'(OVF), 0);
      RST_N = 1'b1;
      #1;
      check("rst_in_ready", int'(IN_READY), 1);
      step();

      // Directed single transactions, including exact range edges.
      send_one("basic", 100, 10, 0, 30, 0);
`ifdef MUL_SUB_SAT_EN
      send_one("neg", 10, 10, 0, 0, 1);
      send_one("pos", 200, 10, 1, 255, 1);
      send_one("just_over", 249, 1, 1, 255, 1);
`else
      send_one("neg", 10, 10, 0, 196, 1);
      send_one("pos", 200, 10, 1, 14, 1);
      send_one("just_over", 249, 1, 1, 0, 1);
`endif
      send_one("zero_edge", 7, 1, 0, 0, 0);
      send_one("max_edge", 248, 1, 1, 255, 0);
      send_one("b_zero", 77, 0, 0, 77, 0);
      send_one("big_neg", 0, 255, 0, model_x(0, 255, 0), 1);

      // Backpressure: two accepted, third stalled until OUT_READY returns.
      OUT_READY = 1'b0;
      IN_VALID = 1'b1; A = 8'd50; B = 8'd1; MODE = 1'b0;
      check("bp_rdy0", int'(IN_READY), 1);
      step();
      A = 8'd60; B = 8'd2;
      check("bp_rdy1", int'(IN_READY), 1);
      step();
      A = 8'd70; B = 8'd3;
      for (int i = 0; i < 4; i++) begin
         check("bp_stall_rdy", int'(IN_READY), 0);
         check("bp_stall_valid", int'(OUT_VALID), 1);
         check("bp_stall_xout", int'(XOUT), 43);
         step();
      end
      OUT_READY = 1'b1;
      #1;
      check("bp_release_rdy", int'(IN_READY), 1);
      step();
      IN_VALID = 1'b0;
      check("bp_out2", int'(XOUT), 46);
      check("bp_out2_valid", int'(OUT_VALID), 1);
      step();
      check("bp_out3", int'(XOUT), 49);
      check("bp_out3_valid", int'(OUT_VALID), 1);
      step();
      check("bp_drained", int'(OUT_VALID), 0);
      check("bp_hold_xout", int'(XOUT), 49);

      // Full throughput: one result per cycle.
      for (int i = 0; i < 16; i++) begin
         ra[i] = int'($urandom_range(0, 255));
         rb[i] = int'($urandom_range(0, 255));
         rm[i] = int'($urandom_range(0, 1));
      end
      for (int i = 0; i < 17; i++) begin
         if (i < 16) begin
            IN_VALID = 1'b1;
            A = 8'(ra[i]);
            B = 8'(rb[i]);
            MODE = rm[i][0];
            check("tp_in_ready", int'(IN_READY), 1);
         end else begin
            IN_VALID = 1'b0;
         end
         step();
         if (i >= 1) begin
            check("tp_valid", int'(OUT_VALID), 1);
            check("tp_xout", int'(XOUT), model_x(ra[i-1], rb[i-1], rm[i-1]));
            check("tp_ovf", int'(OVF), model_ovf(ra[i-1], rb[i-1], rm[i-1]));
         end
      end
      step();
      check("tp_drained", int'(OUT_VALID), 0);

      // Reset with both stages full discards everything in flight.
      OUT_READY = 1'b0;
      IN_VALID = 1'b1; A = 8'd200; B = 8'd1; MODE = 1'b1;
      step();
      A = 8'd150;
      step();
      IN_VALID = 1'b0;
      check("mid_full_valid", int'(OUT_VALID), 1);
      check("mid_full_rdy", int'(IN_READY), 0);
      RST_N = 1'b0;
      #1;
      check("mid_rst_valid", int'(OUT_VALID), 0);
      check("mid_rst_xout", int'(XOUT), 0);
      step();
      RST_N = 1'b1;
      OUT_READY = 1'b1;
      #1;
      send_one("post_rst", 9, 1, 0, 2, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mul_sub_pipe.md
Name: mul_sub_pipe

Overview:
Parametrised, pipelined successor to the team's fixed 8-bit combinational "A minus 7 times B" process. Computes XOUT = A - COEF*B, or A + COEF*B per transaction, at a generic WIDTH. Two register stages with valid/ready handshake on both sides. Drops into streaming datapaths where the combinational version cannot meet timing or needs backpressure.

Parameters:
WIDTH, 8, bit width of A, B and XOUT (unsigned)
COEF, 7, unsigned multiplier constant applied to B; must satisfy 0 <= COEF < 2**CWIDTH
CWIDTH, 8, bit width used to hold COEF internally

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  asynchronous active-low reset
IN_VALID  in  1  input transaction valid
IN_READY  out  1  block can accept input this cycle
A  in  WIDTH  minuend/addend operand
B  in  WIDTH  operand scaled by COEF
MODE  in  1  0 = A - COEF*B, 1 = A + COEF*B
OUT_VALID  out  1  XOUT holds a valid result
OUT_READY  in  1  downstream accepts result this cycle
XOUT  out  WIDTH  result
OVF  out  1  result was out of range [0, 2**WIDTH-1] before wrap/clamp; qualified by OUT_VALID

Behaviour:
- Reset (RST_N low, async): stage valids V1=V2=0, OUT_VALID=0, XOUT=0, OVF=0, all stage data registers 0. IN_READY follows its equation once RST_N is released, so it reads 1.
- Handshake: input transfer when IN_VALID && IN_READY. Output transfer when OUT_VALID && OUT_READY. IN_VALID/A/B/MODE are sampled only on transfer. XOUT/OVF stay stable while OUT_VALID && !OUT_READY.
- Stage 1 (product):
  - On input transfer, register A, MODE and P = COEF*B at full WIDTH+CWIDTH bits; set V1=1.
  - Otherwise, if stage 1 advances, clear V1.
- Stage 2 (sum/diff):
  - When S2_EN = !V2 || OUT_READY is true, load from stage 1.
  - Full-precision signed result R = A -/+ P, computed at WIDTH+CWIDTH+2 bits.
  - XOUT <= R modulo 2**WIDTH (low WIDTH bits).
  - OVF <= (R < 0) || (R > 2**WIDTH-1).
  - V2 <= V1.
- Ready chain (combinational): S1_EN = !V1 || S2_EN; IN_READY = S1_EN. OUT_VALID = V2.
- Latency: 2 cycles from input transfer to OUT_VALID with OUT_READY held high. Throughput is 1 transaction per cycle.
- Full pipeline (V1=V2=1, OUT_READY=0): IN_READY=0, nothing moves, no data lost or duplicated.
- Simultaneous output transfer and input transfer on a full pipeline: all stages shift in the same cycle, IN_READY=1.
- Empty pipeline: OUT_VALID=0. XOUT/OVF hold their last values (don't-care to consumers).
- COEF=0: XOUT=A, OVF=0. Legal.
- Reset mid-operation: in-flight transactions are discarded. The first post-reset output is the first post-reset input.

Optional Feature:
MUL_SUB_SAT_EN
- Defined: XOUT clamps instead of wrapping. R<0 gives XOUT=0; R>2**WIDTH-1 gives XOUT=2**WIDTH-1. OVF behaves unchanged.
- Undefined: wrap-around as described above.
- Latency, handshake and ports are identical in both builds.

Test Plan:
- Reset then single transfer A=100, B=10, MODE=0, OUT_READY=1 -> OUT_VALID high exactly 2 cycles later, XOUT=30, OVF=0.
- A=10, B=10, MODE=0 -> XOUT=196, OVF=1 (wrap build); XOUT=0, OVF=1 with MUL_SUB_SAT_EN.
- A=200, B=10, MODE=1 -> XOUT=14, OVF=1 (wrap build); XOUT=255, OVF=1 with MUL_SUB_SAT_EN.
- Backpressure: stream inputs (A,B) = (50,1), (60,2), (70,3), MODE=0, with OUT_READY=0 for cycles 0-5 -> IN_READY drops after 2 accepted. Release OUT_READY -> outputs 43, 46, 49 in order, no loss or duplicates.
- Full throughput: 16 back-to-back random transfers, OUT_READY=1 -> 16 results on consecutive cycles matching the reference model; IN_READY never low.
- Assert RST_N low for 1 cycle while V1=V2=1 -> OUT_VALID=0 and XOUT=0 immediately (async). Next input A=9, B=1, MODE=0 -> XOUT=2 as the first output.
